pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, handshaked pipeline stage register for the CPU datapath (ID→EXE, EXE→MEM and later stages). It replaces the fixed-field stall/flush registers with one generic block. Each instance carries an opaque DATA_W-bit bundle under a valid/ready handshake, with synchronous flush. An optional two-entry skid buffer makes the upstream ready signal fully registered, so stall paths no longer have to be combinational across stages. A saturating stall counter is included for performance analysis.

## Interface
Parameters:
- DATA_W, 128, width of the payload bundle (≥1)
- RESET_VAL, '0, value `out_data_o` takes on reset or flush
- CNT_W, 32, width of the stall counter (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high (already decided)
- flush_i  in  1  synchronous flush; kills every held entry
- in_valid_i  in  1  upstream has a bundle
- in_ready_o  out  1  stage accepts a bundle this cycle
- in_data_i  in  DATA_W  upstream bundle
- out_valid_o  out  1  stage presents a bundle
- out_ready_i  in  1  downstream accepts this cycle
- out_data_o  out  DATA_W  presented bundle
- stall_cnt_o  out  CNT_W  count of cycles with out_valid_o=1 and out_ready_i=0

## Operation
- Transfer rule: in-fire = in_valid_i & in_ready_o. Out-fire = out_valid_o & out_ready_i.
- Priority is rst > flush_i > handshake.
- On rst:
  - out_valid_o=0, out_data_o=RESET_VAL, skid entry empty, stall_cnt_o=0
  - in_ready_o=1 in the following cycle
- On flush_i (without rst):
  - identical to reset, except stall_cnt_o is kept
  - a bundle presented in the same cycle is discarded, even if in_ready_o=1
- With the skid buffer (see Configuration), the stage has three states: EMPTY, FULL and SKID. in_ready_o = (state≠SKID).
  - EMPTY: in-fire → FULL, main←in_data_i. Otherwise stay.
  - FULL:
    - in-fire with out-fire → FULL, main←in_data_i
    - out-fire only → EMPTY
    - in-fire only → SKID, skid←in_data_i
    - neither → hold
  - SKID: out-fire → FULL, main←skid. Otherwise hold (in_ready_o=0).
  - out_valid_o = (state≠EMPTY). out_data_o = main.
- After a drain to EMPTY, out_data_o keeps its last value. Downstream must qualify data with out_valid_o.
- While out_valid_o=1 and out_ready_i=0, out_data_o and the skid entry are frozen. Every payload bit holds; there are no partial updates.
- stall_cnt_o increments when out_valid_o & !out_ready_i. It saturates at 2^CNT_W−1 and is cleared only by rst.

## Timing
- Latency: a bundle accepted in cycle n appears on out_data_o with out_valid_o=1 in cycle n+1.
- Throughput: one bundle per cycle when out_ready_i is held at 1.
- With the skid buffer:
  - in_ready_o is a flop output, with no combinational path from out_ready_i.
  - After out_ready_i deasserts, at most one extra bundle is accepted (into skid).
  - From SKID, in_ready_o returns to 1 the cycle after the first out-fire.
- Flush or reset asserted in cycle n: out_valid_o=0 from cycle n+1.
- A bundle presented in cycle n+1 is accepted normally.
- Simultaneous flush_i and in-fire: the flush wins and nothing is stored.

## Configuration
- Macro PIPE_STAGE_SKID_EN.
- Defined: three-state skid implementation as described above, with registered in_ready_o.
- Undefined:
  - single entry; states EMPTY/FULL only
  - in_ready_o = !out_valid_o | out_ready_i, combinational
  - in-fire with out-fire → FULL with new data
  - SKID unreachable, skid register absent
- All other behaviour (flush, reset, stall counter, latency) is identical in both builds.

## Test plan
- Reset, then stream 0x1..0x8 with out_ready_i=1 → out_data_o=0x1..0x8 on consecutive cycles, one cycle after input. stall_cnt_o=0.
- (SKID_EN) FULL with 0xA. Drop out_ready_i for 3 cycles while offering 0xB, 0xC → 0xB taken into skid, in_ready_o=0 next cycle. 0xC is held upstream, out_data_o=0xA frozen, stall_cnt_o=3. On release, outputs are 0xA, 0xB, 0xC in order, with no loss or duplication.
- flush_i in SKID state together with in_valid_i=1, data 0xF → next cycle out_valid_o=0, out_data_o=RESET_VAL, in_ready_o=1. 0xF is never output. stall_cnt_o is unchanged.
- rst asserted mid-stream with stall_cnt_o=5 → next cycle all outputs at reset values, stall_cnt_o=0.
- CNT_W=2, downstream stalled 6 cycles → stall_cnt_o goes 1, 2, 3, 3, 3, 3 (saturates, no wrap).
- (no SKID_EN) out_valid_o=1, out_ready_i=0 → in_ready_o=0 in the same cycle. Raise out_ready_i → in_ready_o=1 in the same cycle and the new bundle is captured.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline stage register with flush and stall counter.
// Latency 1 cycle; backpressure via in_ready_o (registered when PIPE_STAGE_SKID_EN is defined, else combinational).
// Optional feature macro: PIPE_STAGE_SKID_EN (two-entry skid buffer, fully registered upstream ready).
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 128,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int unsigned       CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              in_fire;
  logic              out_fire;
  logic              stalled;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = main_q;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;
  assign stalled     = out_valid_o & ~out_ready_i;

`ifdef PIPE_STAGE_SKID_EN

  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q;

  // Ready is a pure flop: it looks only at the state we are about to enter.
  assign in_ready_o = in_ready_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = RESET_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_FULL;
            main_d  = in_data_i;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end else if (in_fire) begin
            state_d = ST_SKID;
            skid_d  = in_data_i;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            state_d = ST_FULL;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = RESET_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= RESET_VAL;
      skid_q     <= RESET_VAL;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != ST_SKID);
    end
  end

  a_ready_matches_state: assert property (@(posedge clk) disable iff (rst)
    in_ready_o == (state_q != ST_SKID));

  a_skid_frozen: assert property (@(posedge clk)
    (!rst && !flush_i && state_q == ST_SKID && !out_ready_i) |=> $stable(skid_q));

`else

  // Single entry: a full stage can only accept when it is emptied in the same cycle.
  assign in_ready_o = ~out_valid_o | out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = RESET_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_FULL;
            main_d  = in_data_i;
          end
        end
        ST_FULL: begin
          if (in_fire) begin
            main_d = in_data_i;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = RESET_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  a_never_skid: assert property (@(posedge clk) disable iff (rst)
    state_q != ST_SKID);

`endif

  // Saturating; flush deliberately leaves it alone so stall history survives pipeline kills.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stalled && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;

  a_data_frozen: assert property (@(posedge clk)
    (!rst && !flush_i && stalled) |=> $stable(out_data_o));

  a_valid_after_flush: assert property (@(posedge clk)
    (rst || flush_i) |=> !out_valid_o);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed scenarios plus random traffic against a queue model.
module tb_pipe_stage_reg;

  localparam int unsigned       DW   = 16;
  localparam int unsigned       CW   = 3;
  localparam logic [DW-1:0]     RV   = 16'hDEAD;
  localparam int                CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W   (DW),
    .RESET_VAL(RV),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .stall_cnt_o(stall_cnt)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
  endtask

  // Reference model: the stage is a FIFO of at most two (skid) or one entry.
  logic [DW-1:0] q[$];
  logic [DW-1:0] last_m;
  int            cnt_m;
  bit            armed = 1'b0;

  always @(negedge clk) begin
    bit            exp_rdy;
    logic [DW-1:0] exp_dat;
`ifdef PIPE_STAGE_SKID_EN
    exp_rdy = (q.size() < 2);
`else
    exp_rdy = (q.size() == 0) || out_ready;
`endif
    exp_dat = (q.size() != 0) ? q[0] : last_m;
    if (armed) begin
      chk("out_valid", int'(out_valid), int'(q.size() != 0));
      chk("in_ready", int'(in_ready), int'(exp_rdy));
      chk("out_data", int'(out_data), int'(exp_dat));
      chk("stall_cnt", int'(stall_cnt), cnt_m);
    end
    if (rst) begin
      q.delete();
      last_m = RV;
      cnt_m  = 0;
      armed  = 1'b1;
    end else if (armed) begin
      if (q.size() != 0 && !out_ready && cnt_m < CMAX) cnt_m++;
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (flush) begin
        q.delete();
        last_m = RV;
      end else if (in_valid && exp_rdy) begin
        q.push_back(in_data);
      end
      if (q.size() != 0) last_m = q[0];
    end
  end

  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit r,
                     input bit f, input bit x = 1'b0);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    rst       = x;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0);

    // Streaming 1..8 at full rate.
    for (int i = 1; i <= 8; i++) cyc(1, DW'(i), 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);

    // Stall with upstream pressure, then release: A, B, C in order.
    cyc(1, 16'h000A, 1, 0);
    cyc(1, 16'h000B, 0, 0);
    cyc(1, 16'h000C, 0, 0);
    cyc(1, 16'h000C, 0, 0);
    cyc(1, 16'h000C, 1, 0);
    cyc(1, 16'h000C, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);

    // Flush while holding two entries with 0xF offered.
    cyc(1, 16'h0001, 1, 0);
    cyc(1, 16'h0002, 0, 0);
    cyc(1, 16'h000F, 1, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);

    // Push the counter to 5, then reset mid-stream.
    cyc(1, 16'h0003, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 16'h0004, 1, 1, 1);
    cyc(0, 0, 1, 0);

    // Long stall: the counter must saturate at its maximum, not wrap.
    cyc(1, 16'h0007, 1, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 4) != 0, DW'($urandom), ($urandom % 3) != 0,
          ($urandom % 40) == 0, ($urandom % 200) == 0);
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
